// File: rtl/dynamic_branch_predictor_if.sv
// Fetch-side lookup, resolve-side training and RAS control bundle for the
// dynamic branch predictor. The master is the fetch/execute pipeline; the
// slave is the predictor.
interface dynamic_branch_predictor_if #(
  parameter int XLEN = 32
);
  // Lookup / RAS control from fetch
  logic            predict_valid;
  logic [XLEN-1:0] pc_plus_four;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic            jalr;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  // Training from the branch evaluator
  logic            update_valid;
  logic [XLEN-1:0] update_pc_plus_four;
  logic            update_taken;
  // Mispredict recovery
  logic            flush;
  // Prediction results
  logic            branch_predicted_taken;
  logic            ras_valid;
  logic [XLEN-1:0] ras_target;

  modport master (
    output predict_valid, pc_plus_four, branch_target, jump, jalr, rd, rs1,
    output update_valid, update_pc_plus_four, update_taken, flush,
    input  branch_predicted_taken, ras_valid, ras_target
  );

  modport slave (
    input  predict_valid, pc_plus_four, branch_target, jump, jalr, rd, rs1,
    input  update_valid, update_pc_plus_four, update_taken, flush,
    output branch_predicted_taken, ras_valid, ras_target
  );
endinterface

// File: rtl/dynamic_branch_predictor.sv
// Fetch-stage branch predictor: per-PC table of 2-bit saturating counters
// (untagged, static backward-taken fallback for untrained entries) plus a
// circular return-address stack driven by JAL/JALR link-register hints.
// All predictions are combinational from registered state; all state
// changes land on the next rising clock edge.
module dynamic_branch_predictor #(
  parameter int XLEN           = 32,
  parameter int BHT_INDEX_BITS = 6,
  parameter int RAS_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  dynamic_branch_predictor_if.slave     bp
);

  localparam int BHT_ENTRIES = 1 << BHT_INDEX_BITS;
  localparam int PTR_W       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W       = $clog2(RAS_DEPTH + 1);

  // ---------------------------------------------------------------------
  // Branch history table
  // ---------------------------------------------------------------------
  logic [BHT_INDEX_BITS-1:0] lookup_idx;
  logic [BHT_INDEX_BITS-1:0] train_idx;
  logic [BHT_ENTRIES-1:0]    bht_valid;
  logic [1:0]                bht_ctr [BHT_ENTRIES];

  assign lookup_idx = bp.pc_plus_four[BHT_INDEX_BITS+1:2];
  assign train_idx  = bp.update_pc_plus_four[BHT_INDEX_BITS+1:2];

  // Only the index slice of the training address matters; fold the rest
  // away so it is visibly intentional.
  logic unused_update_bits;
  assign unused_update_bits = ^{bp.update_pc_plus_four[XLEN-1:BHT_INDEX_BITS+2],
                                bp.update_pc_plus_four[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
      logic       valid_reg;
      logic [1:0] ctr_reg;

      // Train this entry: first touch seeds a weak counter, later touches saturate
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg <= 1'b0;
          ctr_reg   <= 2'b01;
        end else if (bp.update_valid && (train_idx == BHT_INDEX_BITS'(gi))) begin
          valid_reg <= 1'b1;
          if (!valid_reg) begin
            ctr_reg <= bp.update_taken ? 2'b10 : 2'b01;
          end else if (bp.update_taken) begin
            ctr_reg <= (ctr_reg == 2'b11) ? 2'b11 : ctr_reg + 2'b01;
          end else begin
            ctr_reg <= (ctr_reg == 2'b00) ? 2'b00 : ctr_reg - 2'b01;
          end
        end
      end

      assign bht_valid[gi] = valid_reg;
      assign bht_ctr[gi]   = ctr_reg;
    end
  endgenerate

  // Jumps are always taken; a qualified non-jump lookup is a conditional
  // branch that uses the table, or the static rule while untrained.
  logic is_backward;
  assign is_backward = (bp.branch_target < bp.pc_plus_four);

  // Select the prediction source
  always_comb begin
    bp.branch_predicted_taken = 1'b0;
    if (bp.jump) begin
      bp.branch_predicted_taken = 1'b1;
    end else if (bp.predict_valid) begin
      if (bht_valid[lookup_idx]) begin
        bp.branch_predicted_taken = bht_ctr[lookup_idx][1];
      end else begin
        bp.branch_predicted_taken = is_backward;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Return-address stack
  // ---------------------------------------------------------------------
  logic [XLEN-1:0]  ras_entry [RAS_DEPTH];
  logic [PTR_W-1:0] top_reg, top_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] top_inc, top_dec;
  logic             link_rd, link_rs1;
  logic             do_push, do_pop, do_replace;
  logic             ras_we;
  logic [PTR_W-1:0] ras_widx;

  assign link_rd  = (bp.rd  == 5'd1) || (bp.rd  == 5'd5);
  assign link_rs1 = (bp.rs1 == 5'd1) || (bp.rs1 == 5'd5);

  assign top_inc = (top_reg == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_reg + 1'b1;
  assign top_dec = (top_reg == '0) ? PTR_W'(RAS_DEPTH - 1) : top_reg - 1'b1;

  // Decode the RAS action from the link-register hint table; flush wins
  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_replace = 1'b0;
    if (bp.predict_valid && bp.jump && !bp.flush) begin
      if (!bp.jalr) begin
        do_push = link_rd;
      end else begin
        case ({link_rd, link_rs1})
          2'b01:   do_pop  = 1'b1;
          2'b10:   do_push = 1'b1;
          2'b11: begin
            if (bp.rd != bp.rs1) do_replace = 1'b1;
            else                 do_push    = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Next pointer/count and the single entry write port
  always_comb begin
    top_next   = top_reg;
    count_next = count_reg;
    ras_we     = 1'b0;
    ras_widx   = top_reg;
    if (bp.flush) begin
      top_next   = '0;
      count_next = '0;
    end else if (do_push) begin
      top_next   = top_inc;
      ras_we     = 1'b1;
      ras_widx   = top_inc;
      // A full stack drops its oldest entry, which sits at top+1
      if (count_reg != CNT_W'(RAS_DEPTH)) count_next = count_reg + 1'b1;
    end else if (do_pop) begin
      if (count_reg != '0) begin
        top_next   = top_dec;
        count_next = count_reg - 1'b1;
      end
    end else if (do_replace) begin
      ras_we = 1'b1;
      if (count_reg == '0) count_next = CNT_W'(1);
    end
  end

  // Stack pointer and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      top_reg   <= '0;
      count_reg <= '0;
    end else begin
      top_reg   <= top_next;
      count_reg <= count_next;
    end
  end

  generate
    for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
      logic [XLEN-1:0] entry_reg;

      // Capture the return address when this slot is written
      always_ff @(posedge clk) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (ras_we && (ras_widx == PTR_W'(gi))) begin
          entry_reg <= bp.pc_plus_four;
        end
      end

      assign ras_entry[gi] = entry_reg;
    end
  endgenerate

  assign bp.ras_valid  = (count_reg != '0);
  assign bp.ras_target = ras_entry[top_reg];

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Directed bench for dynamic_branch_predictor: a table of BHT lookup/train
// vectors followed by hand-written RAS, flush and reset sequences.
module tb_dynamic_branch_predictor;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_failed;

  dynamic_branch_predictor_if #(.XLEN(32)) bp_if ();

  dynamic_branch_predictor #(
    .XLEN(32),
    .BHT_INDEX_BITS(6),
    .RAS_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bp   (bp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc4;
    logic [31:0] tgt;
    logic        jump;
    logic        upd_valid;
    logic [31:0] upd_pc4;
    logic        upd_taken;
    logic        exp_taken;
  } bht_vec_t;

  bht_vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp_if.predict_valid       = 1'b0;
    bp_if.pc_plus_four        = '0;
    bp_if.branch_target       = '0;
    bp_if.jump                = 1'b0;
    bp_if.jalr                = 1'b0;
    bp_if.rd                  = '0;
    bp_if.rs1                 = '0;
    bp_if.update_valid        = 1'b0;
    bp_if.update_pc_plus_four = '0;
    bp_if.update_taken        = 1'b0;
    bp_if.flush               = 1'b0;
  endtask

  // Drive one RAS-relevant jump for a single cycle
  task automatic jump_op(input logic is_jalr, input logic [4:0] rd_v,
                         input logic [4:0] rs1_v, input logic [31:0] pc4);
    bp_if.predict_valid = 1'b1;
    bp_if.jump          = 1'b1;
    bp_if.jalr          = is_jalr;
    bp_if.rd            = rd_v;
    bp_if.rs1           = rs1_v;
    bp_if.pc_plus_four  = pc4;
    bp_if.branch_target = 32'h0;
  endtask

  task automatic predict_branch(input logic [31:0] pc4, input logic [31:0] tgt);
    idle();
    bp_if.predict_valid = 1'b1;
    bp_if.pc_plus_four  = pc4;
    bp_if.branch_target = tgt;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;

    // index(0x104)=1, index(0x204)=1 (alias), index(0x108)=2
    vecs[0]  = '{"static_backward",  32'h104, 32'h080, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1};
    vecs[1]  = '{"static_forward",   32'h104, 32'h200, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0};
    vecs[2]  = '{"train_nt_no_byp",  32'h104, 32'h080, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1};
    vecs[3]  = '{"ctr01_t",          32'h104, 32'h080, 1'b0, 1'b1, 32'h104, 1'b1, 1'b0};
    vecs[4]  = '{"ctr10_t",          32'h104, 32'h080, 1'b0, 1'b1, 32'h104, 1'b1, 1'b1};
    vecs[5]  = '{"ctr11_t_sat",      32'h104, 32'h080, 1'b0, 1'b1, 32'h104, 1'b1, 1'b1};
    vecs[6]  = '{"ctr11_nt",         32'h104, 32'h080, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1};
    vecs[7]  = '{"ctr10_hold",       32'h104, 32'h080, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1};
    vecs[8]  = '{"alias_fwd_ctr10",  32'h204, 32'h300, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1};
    vecs[9]  = '{"idx2_static_fwd",  32'h108, 32'h300, 1'b0, 1'b1, 32'h108, 1'b0, 1'b0};
    vecs[10] = '{"idx2_ctr01_nt",    32'h108, 32'h300, 1'b0, 1'b1, 32'h108, 1'b0, 1'b0};
    vecs[11] = '{"idx2_ctr00_back",  32'h108, 32'h080, 1'b0, 1'b1, 32'h108, 1'b1, 1'b0};
    vecs[12] = '{"idx2_ctr01_back",  32'h108, 32'h080, 1'b0, 1'b1, 32'h108, 1'b1, 1'b0};
    vecs[13] = '{"idx2_ctr10",       32'h108, 32'h300, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1};
    vecs[14] = '{"jump_fwd",         32'h300, 32'h400, 1'b1, 1'b0, 32'h000, 1'b0, 1'b1};

    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check("reset_ras_valid",  {31'b0, bp_if.ras_valid}, 32'h0);
    check("reset_ras_target", bp_if.ras_target, 32'h0);

    // ---------------- table-driven BHT vectors ----------------
    for (int i = 0; i < 15; i++) begin
      idle();
      bp_if.predict_valid       = 1'b1;
      bp_if.pc_plus_four        = vecs[i].pc4;
      bp_if.branch_target       = vecs[i].tgt;
      bp_if.jump                = vecs[i].jump;
      bp_if.update_valid        = vecs[i].upd_valid;
      bp_if.update_pc_plus_four = vecs[i].upd_pc4;
      bp_if.update_taken        = vecs[i].upd_taken;
      #1;
      check(vecs[i].name, {31'b0, bp_if.branch_predicted_taken}, {31'b0, vecs[i].exp_taken});
      tick();
    end
    idle();
    #1;
    check("bht_no_ras_change", {31'b0, bp_if.ras_valid}, 32'h0);

    // ---------------- JAL push, JALR pop ----------------
    jump_op(1'b0, 5'd1, 5'd0, 32'h1004);
    tick();
    jump_op(1'b1, 5'd0, 5'd1, 32'h2000);
    #1;
    check("call_ras_valid",  {31'b0, bp_if.ras_valid}, 32'h1);
    check("call_ras_target", bp_if.ras_target, 32'h1004);
    tick();
    idle();
    #1;
    check("ret_ras_empty", {31'b0, bp_if.ras_valid}, 32'h0);

    // ---------------- overflow then drain ----------------
    for (int i = 1; i <= 5; i++) begin
      jump_op(1'b0, 5'd5, 5'd0, 32'(i * 16));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      jump_op(1'b1, 5'd0, 5'd5, 32'h0);
      #1;
      check($sformatf("drain_top%0d", i), bp_if.ras_target, 32'(32'h50 - i * 16));
      tick();
    end
    idle();
    #1;
    check("drain_empty", {31'b0, bp_if.ras_valid}, 32'h0);

    // pop on empty has no effect
    jump_op(1'b1, 5'd0, 5'd1, 32'h0);
    tick();
    idle();
    #1;
    check("pop_empty", {31'b0, bp_if.ras_valid}, 32'h0);

    // ---------------- replace / push variants ----------------
    jump_op(1'b1, 5'd1, 5'd5, 32'h77C);   // replace on empty -> count 1
    tick();
    idle();
    #1;
    check("replace_empty_valid", {31'b0, bp_if.ras_valid}, 32'h1);
    check("replace_empty_tgt",   bp_if.ras_target, 32'h77C);
    jump_op(1'b0, 5'd1, 5'd0, 32'h800);   // push
    tick();
    jump_op(1'b1, 5'd5, 5'd1, 32'h900);   // replace top
    tick();
    idle();
    #1;
    check("replace_top", bp_if.ras_target, 32'h900);
    jump_op(1'b1, 5'd0, 5'd1, 32'h0);     // pop -> 0x77C underneath
    tick();
    idle();
    #1;
    check("replace_kept_count", bp_if.ras_target, 32'h77C);
    check("replace_kept_valid", {31'b0, bp_if.ras_valid}, 32'h1);
    jump_op(1'b1, 5'd1, 5'd1, 32'hA00);   // rd==rs1 -> push
    tick();
    jump_op(1'b1, 5'd1, 5'd0, 32'hB00);   // link rd only -> push
    tick();
    jump_op(1'b1, 5'd0, 5'd0, 32'hBBB);   // no link -> nothing
    tick();
    idle();
    #1;
    check("jalr_push_tgt", bp_if.ras_target, 32'hB00);
    // push not qualified by predict_valid is ignored
    jump_op(1'b0, 5'd1, 5'd0, 32'hCCC);
    bp_if.predict_valid = 1'b0;
    tick();
    idle();
    #1;
    check("unqualified_push", bp_if.ras_target, 32'hB00);

    // ---------------- flush vs push, training during flush ----------------
    jump_op(1'b0, 5'd1, 5'd0, 32'hC00);
    bp_if.flush               = 1'b1;
    bp_if.update_valid        = 1'b1;
    bp_if.update_pc_plus_four = 32'h110;
    bp_if.update_taken        = 1'b1;
    tick();
    idle();
    #1;
    check("flush_ras_valid",  {31'b0, bp_if.ras_valid}, 32'h0);
    check("flush_keeps_entry", bp_if.ras_target, 32'h40);
    predict_branch(32'h110, 32'h400);
    #1;
    check("train_during_flush", {31'b0, bp_if.branch_predicted_taken}, 32'h1);
    jump_op(1'b0, 5'd1, 5'd0, 32'hD00);
    tick();
    idle();
    #1;
    check("push_after_flush", bp_if.ras_target, 32'hD00);

    // ---------------- reset while training ----------------
    idle();
    reset                     = 1'b1;
    bp_if.update_valid        = 1'b1;
    bp_if.update_pc_plus_four = 32'h10C;
    bp_if.update_taken        = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    predict_branch(32'h10C, 32'h200);
    #1;
    check("reset_blocks_train", {31'b0, bp_if.branch_predicted_taken}, 32'h0);
    predict_branch(32'h104, 32'h200);
    #1;
    check("reset_clears_bht", {31'b0, bp_if.branch_predicted_taken}, 32'h0);
    check("reset2_ras_valid", {31'b0, bp_if.ras_valid}, 32'h0);
    check("reset2_ras_target", bp_if.ras_target, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
